fifo_uart_tx_drain: RTL and testbench

//   Downstream consumer of the 16-bit FIFO memory. Pops one word whenever the FIFO is non-empty
//   and the block is enabled, then sends it as two UART 8N1 bytes on a serial line.

---
 rtl/fifo_uart_tx_drain.sv | 186 ++++++++++++++++++
 tb/tb_fifo_uart_tx_drain.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx_drain.sv
// FIFO drain: pops 16-bit words and sends them as two UART bytes.
// Build option: UART_TX_PARITY_EN adds an even-parity bit per byte.
`timescale 1ns/1ps

module fifo_uart_tx_drain #(
  parameter int c_CLKS_PER_BIT   = 217,
  parameter int c_LOW_BYTE_FIRST = 1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Enable,
  input  logic        i_Fifo_Empty,
  output logic        o_Read_En,
  input  logic [15:0] i_Data_In,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic [15:0] o_Word_Count
);

  localparam int BAUD_W = $clog2(c_CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(c_CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ_WAIT = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY    = 3'd4,
`endif
    S_STOP      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              byte_q, byte_d;
  logic [15:0]       word_q, word_d;
  logic [15:0]       count_q, count_d;

  logic       read_en;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;
  logic       baud_last;
  logic       hi_sel;
  logic [7:0] cur_byte;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  // byte index 0 maps to the low byte unless the order is reversed
  always_comb begin
    hi_sel = (c_LOW_BYTE_FIRST != 0) ? byte_q : ~byte_q;
    cur_byte = hi_sel ? word_q[15:8] : word_q[7:0];
    baud_last = (baud_q == BAUD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    word_d    = word_q;
    count_d   = count_q;
    read_en   = 1'b0;
    tx_serial = 1'b1;
    tx_active = 1'b0;
    tx_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // no pop while reset is held, so no word is lost
        if (i_Enable && !i_Fifo_Empty && i_Reset_n) begin
          read_en = 1'b1;
          state_d = S_READ_WAIT;
        end
      end

      S_READ_WAIT: begin
        word_d  = i_Data_In;
        byte_d  = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_START;
      end

      S_START: begin
        tx_serial = 1'b0;
        tx_active = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        tx_serial = cur_byte[bit_q];
        tx_active = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_serial = ^cur_byte;
        tx_active = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_serial = 1'b1;
        tx_active = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DONE: begin
        tx_done = 1'b1;
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_Read_En    = read_en;
  assign o_Tx_Serial  = tx_serial;
  assign o_Tx_Active  = tx_active;
  assign o_Tx_Done    = tx_done;
  assign o_Word_Count = count_q;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: FIFO model, UART receiver scoreboard.
// Follows UART_TX_PARITY_EN when the design is built with it.
`timescale 1ns/1ps

module tb_fifo_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PER = 2 * NB * CPB + 3;
  // cycle offset from the pop strobe to data bit 3 of byte 1
  localparam int OFF6 = 2 + NB * CPB + 4 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty = 1'b1;
  logic        read_en;
  logic [15:0] data_in = 16'h0;
  logic        tx_serial;
  logic        tx_active;
  logic        tx_done;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  int          rd_log[$];

  int rd_cnt = 0;
  int done_cnt = 0;
  int last_rd_cyc = 0;
  int exp_words = 0;
  bit wc_pend = 0;
  bit pop_pend = 0;
  bit any_rd, any_low, any_act;

  int         rx_busy = 0;
  int         rx_cnt = 0;
  int         rx_k = 0;
  logic [7:0] rx_byte = 8'h0;

  fifo_uart_tx_drain #(
    .c_CLKS_PER_BIT(CPB),
    .c_LOW_BYTE_FIRST(1)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Enable    (enable),
    .i_Fifo_Empty(fifo_empty),
    .o_Read_En   (read_en),
    .i_Data_In   (data_in),
    .o_Tx_Serial (tx_serial),
    .o_Tx_Active (tx_active),
    .o_Tx_Done   (tx_done),
    .o_Word_Count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO model: data valid the cycle after the pop, junk otherwise
  initial forever begin
    @(posedge clk);
    #1;
    if (pop_pend) begin
      pop_pend = 0;
      if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
    end else begin
      data_in = 16'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // strobe / done / word-count monitor
  always @(negedge clk) begin
    if (read_en) any_rd = 1;
    if (!tx_serial) any_low = 1;
    if (tx_active) any_act = 1;
    if (!rst_n) begin
      exp_words = 0;
      wc_pend = 0;
    end else begin
      if (wc_pend) begin
        chk("word_count", 32'(word_count), 32'(exp_words));
        wc_pend = 0;
      end
      if (read_en) begin
        rd_cnt++;
        chk("rd_nonempty", 32'(fifo_empty), 32'(0));
        pop_pend = 1;
        rd_log.push_back(cyc);
        last_rd_cyc = cyc;
      end
      if (tx_done) begin
        done_cnt++;
        chk("done_latency", 32'(cyc - last_rd_cyc), 32'(PER - 1));
        exp_words++;
        wc_pend = 1;
      end
    end
  end

  // UART receiver: samples mid-bit and pops the byte scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_busy = 0;
    end else if (rx_busy != 0) begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_k = rx_cnt / CPB;
        if (rx_k == 0) begin
          chk("start_bit", 32'(tx_serial), 32'(0));
        end else if (rx_k <= 8) begin
          rx_byte[rx_k-1] = tx_serial;
        end else if (rx_k < NB - 1) begin
          chk("parity_bit", 32'(tx_serial), 32'(^rx_byte));
        end else begin
          chk("stop_bit", 32'(tx_serial), 32'(1));
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_byte: got %0h expected none", rx_byte);
          end else begin
            chk("rx_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
          end
          rx_busy = 0;
        end
      end
    end else if (tx_serial == 1'b0) begin
      rx_busy = 1;
      rx_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_word(input logic [15:0] w,
                           input logic [7:0] b0,
                           input logic [7:0] b1);
    fifo_q.push_back(w);
    exp_bytes.push_back(b0);
    exp_bytes.push_back(b1);
  endtask

  task automatic wait_rd(input int target, input int lim, input string nm);
    int t = 0;
    while (rd_cnt < target && t < lim) begin
      tick(1);
      t++;
    end
    checks++;
    if (rd_cnt < target) begin
      errors++;
      $display("FAIL %s: got %0d strobes expected %0d", nm, rd_cnt, target);
    end
  endtask

  task automatic wait_done(input int target, input int lim, input string nm);
    int t = 0;
    while (done_cnt < target && t < lim) begin
      tick(1);
      t++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s: got %0d done expected %0d", nm, done_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int r0, d0, n;
    rst_n = 1'b0;
    enable = 1'b0;

    // 1. reset
    do_reset();
    chk("rst_serial", 32'(tx_serial), 32'(1));
    chk("rst_read_en", 32'(read_en), 32'(0));
    chk("rst_active", 32'(tx_active), 32'(0));
    chk("rst_done", 32'(tx_done), 32'(0));
    chk("rst_count", 32'(word_count), 32'(0));

    // 2. single word
    r0 = rd_cnt;
    d0 = done_cnt;
    push_word(16'hBEEF, 8'hEF, 8'hBE);
    enable = 1'b1;
    wait_rd(r0 + 1, 20, "t2_rd");
    wait_done(d0 + 1, PER + 10, "t2_done");
    tick(5);
    chk("t2_rd_pulses", 32'(rd_cnt - r0), 32'(1));
    chk("t2_count", 32'(word_count), 32'(1));

    // 3. empty FIFO, enabled
    any_rd = 0;
    any_low = 0;
    any_act = 0;
    tick(200);
    chk("t3_no_read", 32'(any_rd), 32'(0));
    chk("t3_line_high", 32'(any_low), 32'(0));
    chk("t3_inactive", 32'(any_act), 32'(0));

    // 4. three words back to back after a fresh reset
    do_reset();
    chk("t4_rst_count", 32'(word_count), 32'(0));
    r0 = rd_cnt;
    d0 = done_cnt;
    push_word(16'h0001, 8'h01, 8'h00);
    push_word(16'h0203, 8'h03, 8'h02);
    push_word(16'hFFFF, 8'hFF, 8'hFF);
    wait_done(d0 + 3, 3 * PER + 30, "t4_done");
    tick(3);
    chk("t4_rd_pulses", 32'(rd_cnt - r0), 32'(3));
    n = rd_log.size();
    if (n >= 3) begin
      chk("t4_gap1", 32'(rd_log[n-2] - rd_log[n-3]), 32'(PER));
      chk("t4_gap2", 32'(rd_log[n-1] - rd_log[n-2]), 32'(PER));
    end
    chk("t4_count", 32'(word_count), 32'(3));

    // 5. enable drops during byte 0
    r0 = rd_cnt;
    d0 = done_cnt;
    push_word(16'h5AA5, 8'hA5, 8'h5A);
    push_word(16'hC33C, 8'h3C, 8'hC3);
    wait_rd(r0 + 1, 20, "t5_rd");
    tick(10);
    enable = 1'b0;
    wait_done(d0 + 1, PER + 10, "t5_done");
    tick(PER + 20);
    chk("t5_one_pop", 32'(rd_cnt - r0), 32'(1));
    chk("t5_one_done", 32'(done_cnt - d0), 32'(1));
    chk("t5_count", 32'(word_count), 32'(4));
    enable = 1'b1;
    wait_done(d0 + 2, PER + 30, "t5_resume");
    tick(3);
    chk("t5_two_pops", 32'(rd_cnt - r0), 32'(2));
    chk("t5_count2", 32'(word_count), 32'(5));

    // 6. reset during data bit 3 of byte 1
    r0 = rd_cnt;
    d0 = done_cnt;
    push_word(16'h1234, 8'h34, 8'h12);
    wait_rd(r0 + 1, 20, "t6_rd");
    n = 0;
    while (cyc < last_rd_cyc + OFF6 && n < 200) begin
      tick(1);
      n++;
    end
    rst_n = 1'b0;
    tick(1);
    chk("t6_line_high", 32'(tx_serial), 32'(1));
    chk("t6_inactive", 32'(tx_active), 32'(0));
    chk("t6_count", 32'(word_count), 32'(0));
    exp_bytes.delete();
    rst_n = 1'b1;
    tick(PER + 20);
    chk("t6_no_done", 32'(done_cnt - d0), 32'(0));
    chk("t6_count2", 32'(word_count), 32'(0));
    chk("t6_idle_line", 32'(tx_serial), 32'(1));

    chk("bytes_left", 32'(exp_bytes.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
